mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory-stage access controller between the EX/MEM pipe register and the MEM/WB pipe register.
- Issues loads and stores from the M stage to the data-memory/camera bus using a req/ack handshake with variable latency.
- Stalls the upstream pipeline while an access is in flight and produces RD for the MEM/WB register.
- Bounds every access with a timeout and raises a sticky error when it expires.

Parameters:
- TIMEOUT_CYCLES, 16: maximum number of REQ-state cycles to wait for bus_ack before aborting; must be ≥1. Counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- ValidM  in  1  M-stage instruction is valid
- MemToRegM  in  1  M-stage instruction is a load
- MemWriteM  in  1  M-stage instruction is a store
- ByteM  in  1  byte access (LDRB/STRB); used only with BYTE_ACCESS_EN
- ALUOutM  in  32  effective address
- WriteDataM  in  32  store data
- bus_req  out  1  access request, held until ack
- bus_we  out  1  1 = write
- bus_addr  out  32  bus address
- bus_wdata  out  32  write data
- bus_be  out  4  byte enables
- bus_rdata  in  32  read data, valid when bus_ack=1
- bus_ack  in  1  access complete
- RD  out  32  load data to MEM/WB
- StallM  out  1  freeze the F/D/E/M pipe registers
- BubbleM  out  1  MEM/WB must capture a bubble; top level gates RegWriteIn with ~BubbleM
- ErrM  out  1  sticky bus-timeout flag

Behaviour:
- Reset (synchronous, active-high, takes effect at the clock edge):
  - state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, RD=0, ErrM=0, timeout counter=0.
  - Reset mid-access aborts the access: bus_req is 0 from the next cycle, and a bus_ack arriving afterwards is ignored.
- Define acc = ValidM & (MemToRegM | MemWriteM).
- StallM = (state==IDLE & acc) | (state==REQ). BubbleM = StallM.
- State IDLE:
  - RD=0 and bus_req=0.
  - If acc, latch the transaction into the bus output registers:
    - bus_addr = {ALUOutM[31:2], 2'b00}
    - bus_we = MemWriteM
    - bus_wdata = WriteDataM
    - bus_be = 4'hF
  - Also latch the load flag, clear the counter, and go to REQ.
  - A store with MemToRegM also set is treated as a store.
- State REQ:
  - bus_req=1; bus_addr, bus_we, bus_wdata and bus_be are held stable.
  - Changes on M-stage inputs are ignored.
  - On bus_ack: if the access is a load, RD captures bus_rdata (after byte select), otherwise RD=0; go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 without ack: ErrM=1, RD=0, go to DONE.
  - An ack in the same cycle as the timeout takes priority: success, and ErrM is not set.
- State DONE:
  - bus_req=0, StallM=0; RD is held.
  - The instruction advances into MEM/WB at the end of this cycle.
  - Always returns to IDLE, with RD cleared to 0 there.
  - Back-to-back accesses therefore take one IDLE cycle each.
- Latency: with ack in the first REQ cycle, a memory instruction occupies M for 3 cycles (IDLE, REQ, DONE), with StallM high for 2.
- Non-memory instructions: no stall, no bus activity, RD=0.
- bus_ack outside REQ is ignored.
- ErrM remains 1 until reset.

Optional Feature:
- Macro BYTE_ACCESS_EN.
- Defined, with ByteM=1 latched in IDLE:
  - bus_addr keeps ALUOutM[1:0].
  - bus_be = 4'b0001 << ALUOutM[1:0].
  - bus_wdata = {4{WriteDataM[7:0]}}.
  - On load, RD = zero-extended byte of bus_rdata selected by addr[1:0].
- Not defined: ByteM is ignored and all accesses are word accesses as above.

Test Plan:
1. Word load: ALUOutM=0x103, MemToRegM=1, ack on 2nd REQ cycle with bus_rdata=0x12345678.
   - Expect bus_addr=0x100, be=F, we=0.
   - StallM/BubbleM high for 3 cycles; RD=0x12345678 in DONE; RD=0 next cycle.
2. Store: ALUOutM=0x104, WriteDataM=0xCAFEF00D, immediate ack.
   - Expect we=1, wdata=0xCAFEF00D, be=F, bus_req high exactly 1 cycle, RD=0.
3. Non-memory instruction for 5 cycles.
   - Expect StallM=0, bus_req=0, RD=0.
   - A stray bus_ack pulse has no effect.
4. TIMEOUT_CYCLES=8, load with no ack.
   - Expect exactly 8 REQ cycles, then DONE with RD=0 and ErrM=1.
   - ErrM stays 1 through a following successful access and clears only on reset.
5. Assert reset on the 3rd REQ cycle of a load.
   - Next cycle: bus_req=0, state IDLE, ErrM=0, RD=0.
   - An ack arriving one cycle later is ignored.
6. BYTE_ACCESS_EN defined:
   - LDRB at 0x203 with bus_rdata=0xAABBCCDD: expect be=4'b1000, RD=0x000000AA.
   - STRB at 0x201 with WriteDataM=0x12345655: expect wdata=0x55555555, be=4'b0010.

Source files
------------

// File: rtl/mem_access_stage.sv
// M-stage load/store controller: issues one req/ack bus access per memory instruction,
// stalls the pipe while it is in flight, and bounds it with a timeout. Optional macro: BYTE_ACCESS_EN.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16  // must be >= 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ValidM,
  input  logic        MemToRegM,
  input  logic        MemWriteM,
  input  logic        ByteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [31:0] RD,
  output logic        StallM,
  output logic        BubbleM,
  output logic        ErrM
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               bus_req_q, bus_req_d;
  logic               bus_we_q, bus_we_d;
  logic [31:0]        bus_addr_q, bus_addr_d;
  logic [31:0]        bus_wdata_q, bus_wdata_d;
  logic [3:0]         bus_be_q, bus_be_d;
  logic [31:0]        rd_q, rd_d;
  logic               err_q, err_d;
  logic               load_q, load_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               acc;
  logic [31:0]        issue_addr;
  logic [31:0]        issue_wdata;
  logic [3:0]         issue_be;
  logic [31:0]        load_data;

  assign acc = ValidM & (MemToRegM | MemWriteM);

`ifdef BYTE_ACCESS_EN
  logic byte_q, byte_d;

  // Byte lanes follow the low address bits; store data is replicated to every lane.
  assign issue_addr  = ByteM ? ALUOutM : {ALUOutM[31:2], 2'b00};
  assign issue_be    = ByteM ? (4'b0001 << ALUOutM[1:0]) : 4'hF;
  assign issue_wdata = ByteM ? {4{WriteDataM[7:0]}} : WriteDataM;
  assign load_data   = byte_q ? {24'b0, bus_rdata[{bus_addr_q[1:0], 3'b000} +: 8]} : bus_rdata;
`else
  logic unused_byte;

  assign issue_addr  = {ALUOutM[31:2], 2'b00};
  assign issue_be    = 4'hF;
  assign issue_wdata = WriteDataM;
  assign load_data   = bus_rdata;
  assign unused_byte = ^{ByteM, ALUOutM[1:0]};
`endif

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    rd_d        = rd_q;
    err_d       = err_q;
    load_d      = load_q;
    cnt_d       = cnt_q;
`ifdef BYTE_ACCESS_EN
    byte_d      = byte_q;
`endif

    case (state_q)
      IDLE: begin
        bus_req_d = 1'b0;
        rd_d      = 32'b0;
        if (acc) begin
          bus_addr_d  = issue_addr;
          bus_we_d    = MemWriteM;
          bus_wdata_d = issue_wdata;
          bus_be_d    = issue_be;
          // A store that also claims MemToReg is still a store.
          load_d      = ~MemWriteM;
          cnt_d       = '0;
          bus_req_d   = 1'b1;
          state_d     = REQ;
`ifdef BYTE_ACCESS_EN
          byte_d      = ByteM;
`endif
        end
      end

      REQ: begin
        if (bus_ack) begin
          rd_d      = load_q ? load_data : 32'b0;
          bus_req_d = 1'b0;
          state_d   = DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d     = 1'b1;
          rd_d      = 32'b0;
          bus_req_d = 1'b0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        bus_req_d = 1'b0;
        rd_d      = 32'b0;
        state_d   = IDLE;
      end

      default: begin
        bus_req_d = 1'b0;
        rd_d      = 32'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'b0;
      bus_wdata_q <= 32'b0;
      bus_be_q    <= 4'b0;
      rd_q        <= 32'b0;
      err_q       <= 1'b0;
      load_q      <= 1'b0;
      cnt_q       <= '0;
`ifdef BYTE_ACCESS_EN
      byte_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      rd_q        <= rd_d;
      err_q       <= err_d;
      load_q      <= load_d;
      cnt_q       <= cnt_d;
`ifdef BYTE_ACCESS_EN
      byte_q      <= byte_d;
`endif
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;
  assign RD        = rd_q;
  assign ErrM      = err_q;
  // The issuing IDLE cycle stalls too, so the instruction stays put until DONE.
  assign StallM    = ((state_q == IDLE) & acc) | (state_q == REQ);
  assign BubbleM   = StallM;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (TIMEOUT_CYCLES=8); byte checks adapt to BYTE_ACCESS_EN.
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic        ValidM, MemToRegM, MemWriteM, ByteM;
  logic [31:0] ALUOutM, WriteDataM;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [31:0] RD;
  logic        StallM, BubbleM, ErrM;

  int tests_run = 0;
  int tests_failed = 0;
  int n;

  mem_access_stage #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .ValidM     (ValidM),
    .MemToRegM  (MemToRegM),
    .MemWriteM  (MemWriteM),
    .ByteM      (ByteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack),
    .RD         (RD),
    .StallM     (StallM),
    .BubbleM    (BubbleM),
    .ErrM       (ErrM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and let registered outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ValidM = 1'b0; MemToRegM = 1'b0; MemWriteM = 1'b0; ByteM = 1'b0;
    ALUOutM = 32'h0; WriteDataM = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    #1;
    check_eq("rst_req",   {31'b0, bus_req}, 32'h0);
    check_eq("rst_we",    {31'b0, bus_we},  32'h0);
    check_eq("rst_addr",  bus_addr,  32'h0);
    check_eq("rst_wdata", bus_wdata, 32'h0);
    check_eq("rst_be",    {28'b0, bus_be}, 32'h0);
    check_eq("rst_rd",    RD, 32'h0);
    check_eq("rst_err",   {31'b0, ErrM}, 32'h0);
    check_eq("rst_stall", {31'b0, StallM}, 32'h0);
    $display("[TB] reset checked");

    // 1: word load, ack on the second REQ cycle
    ValidM = 1'b1; MemToRegM = 1'b1; ALUOutM = 32'h103; #1;
    check_eq("ld_stall_idle",  {31'b0, StallM},  32'h1);
    check_eq("ld_bubble_idle", {31'b0, BubbleM}, 32'h1);
    step();
    check_eq("ld_req1",   {31'b0, bus_req}, 32'h1);
    check_eq("ld_addr",   bus_addr, 32'h100);
    check_eq("ld_be",     {28'b0, bus_be}, 32'hF);
    check_eq("ld_we",     {31'b0, bus_we}, 32'h0);
    check_eq("ld_stall1", {31'b0, StallM}, 32'h1);
    step();
    check_eq("ld_stall2", {31'b0, StallM}, 32'h1);
    bus_ack = 1'b1; bus_rdata = 32'h12345678;
    step();
    bus_ack = 1'b0; bus_rdata = 32'h0; #1;
    check_eq("ld_rd_done",    RD, 32'h12345678);
    check_eq("ld_stall_done", {31'b0, StallM}, 32'h0);
    check_eq("ld_req_done",   {31'b0, bus_req}, 32'h0);
    idle_inputs();
    step();
    check_eq("ld_rd_after", RD, 32'h0);
    $display("[TB] word load 0x103 RD=0x%08h", 32'h12345678);

    // 2: store, immediate ack; M-stage changes during REQ must not leak out
    ValidM = 1'b1; MemWriteM = 1'b1; ALUOutM = 32'h104; WriteDataM = 32'hCAFEF00D; #1;
    check_eq("st_stall_idle", {31'b0, StallM}, 32'h1);
    step();
    ALUOutM = 32'h999; WriteDataM = 32'h11111111; MemWriteM = 1'b0; MemToRegM = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'h5A5A5A5A; #1;
    check_eq("st_req",   {31'b0, bus_req}, 32'h1);
    check_eq("st_we",    {31'b0, bus_we}, 32'h1);
    check_eq("st_wdata", bus_wdata, 32'hCAFEF00D);
    check_eq("st_be",    {28'b0, bus_be}, 32'hF);
    check_eq("st_addr",  bus_addr, 32'h104);
    step();
    bus_ack = 1'b0; #1;
    check_eq("st_req_done", {31'b0, bus_req}, 32'h0);
    check_eq("st_rd_done",  RD, 32'h0);
    idle_inputs();
    step();
    $display("[TB] store 0x104 data 0xCAFEF00D");

    // 3: non-memory instructions with a stray ack
    ValidM = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_ack = (i == 2); bus_rdata = 32'hFFFFFFFF;
      step();
      check_eq("nm_stall", {31'b0, StallM}, 32'h0);
      check_eq("nm_req",   {31'b0, bus_req}, 32'h0);
      check_eq("nm_rd",    RD, 32'h0);
    end
    idle_inputs();
    MemToRegM = 1'b1; #1;
    check_eq("nm_invalid_ld_stall", {31'b0, StallM}, 32'h0);
    idle_inputs();
    $display("[TB] non-memory x5 with stray ack");

    // 4: load with no ack times out after exactly 8 REQ cycles
    ValidM = 1'b1; MemToRegM = 1'b1; ALUOutM = 32'h300;
    n = 0;
    step();
    while (bus_req && n < 40) begin
      n++;
      step();
    end
    check_eq("to_req_cycles", n, 32'd8);
    check_eq("to_rd",    RD, 32'h0);
    check_eq("to_err",   {31'b0, ErrM}, 32'h1);
    check_eq("to_stall", {31'b0, StallM}, 32'h0);
    idle_inputs();
    step();
    ValidM = 1'b1; MemWriteM = 1'b1; ALUOutM = 32'h308; WriteDataM = 32'h77;
    step();
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0; #1;
    check_eq("to_err_sticky", {31'b0, ErrM}, 32'h1);
    idle_inputs();
    step();
    $display("[TB] timeout load 0x300 after %0d REQ cycles", n);

    // 5: reset on the third REQ cycle, late ack ignored
    ValidM = 1'b1; MemToRegM = 1'b1; ALUOutM = 32'h400;
    step(); step(); step();
    check_eq("rs_req3", {31'b0, bus_req}, 32'h1);
    reset = 1'b1; ValidM = 1'b0; MemToRegM = 1'b0;
    step();
    reset = 1'b0; #1;
    check_eq("rs_req",   {31'b0, bus_req}, 32'h0);
    check_eq("rs_err",   {31'b0, ErrM}, 32'h0);
    check_eq("rs_rd",    RD, 32'h0);
    check_eq("rs_stall", {31'b0, StallM}, 32'h0);
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    step();
    bus_ack = 1'b0; #1;
    check_eq("rs_ack_rd",  RD, 32'h0);
    check_eq("rs_ack_req", {31'b0, bus_req}, 32'h0);
    step();
    check_eq("rs_ack_rd2", RD, 32'h0);
    idle_inputs();
    $display("[TB] reset mid-access, late ack ignored");

    // 6: byte-flagged load and store
    ValidM = 1'b1; MemToRegM = 1'b1; ByteM = 1'b1; ALUOutM = 32'h203;
    step();
`ifdef BYTE_ACCESS_EN
    check_eq("ldrb_be",   {28'b0, bus_be}, 32'h8);
    check_eq("ldrb_addr", bus_addr, 32'h203);
`else
    check_eq("ldrb_be",   {28'b0, bus_be}, 32'hF);
    check_eq("ldrb_addr", bus_addr, 32'h200);
`endif
    bus_ack = 1'b1; bus_rdata = 32'hAABBCCDD;
    step();
    bus_ack = 1'b0; #1;
`ifdef BYTE_ACCESS_EN
    check_eq("ldrb_rd", RD, 32'h000000AA);
`else
    check_eq("ldrb_rd", RD, 32'hAABBCCDD);
`endif
    idle_inputs();
    step();
    $display("[TB] byte-flagged load 0x203 RD=0x%08h", RD);

    ValidM = 1'b1; MemWriteM = 1'b1; ByteM = 1'b1; ALUOutM = 32'h201; WriteDataM = 32'h12345655;
    step();
`ifdef BYTE_ACCESS_EN
    check_eq("strb_wdata", bus_wdata, 32'h55555555);
    check_eq("strb_be",    {28'b0, bus_be}, 32'h2);
`else
    check_eq("strb_wdata", bus_wdata, 32'h12345655);
    check_eq("strb_be",    {28'b0, bus_be}, 32'hF);
`endif
    check_eq("strb_we", {31'b0, bus_we}, 32'h1);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0; #1;
    check_eq("strb_rd", RD, 32'h0);
    idle_inputs();
    step();
    $display("[TB] byte-flagged store 0x201 data 0x12345655");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
